// File: rtl/spi_cmd_arbiter_if.sv
// Requester-side and SPI-master-side signal bundle of the command arbiter.
// The arbiter plugs into the master modport, its environment into slave.
interface spi_cmd_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int FRAME_W  = 24,
    parameter int BRIGHT_W = 7
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*FRAME_W-1:0] req_frame;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         done;
    logic                       err;
    logic [BRIGHT_W-1:0]        rdata;
    logic                       busy;
    logic                       tx_enb;
    logic [FRAME_W-1:0]         i_frame;
    logic                       cs;
    logic [BRIGHT_W-1:0]        o_frame;

    modport master (
        input  req, req_frame, cs, o_frame,
        output gnt, done, err, rdata, busy, tx_enb, i_frame
    );

    modport slave (
        output req, req_frame, cs, o_frame,
        input  gnt, done, err, rdata, busy, tx_enb, i_frame
    );
endinterface

// File: rtl/spi_cmd_arbiter.sv
// Round-robin scheduler sharing one SPI master among NUM_REQ requesters.
// One 24-bit frame per grant; completion and timeout reported per requester.
module spi_cmd_arbiter #(
    parameter int         NUM_REQ            = 4,
    parameter int         TX_ENB_CYCLES      = 2,
    parameter int         GAP_CYCLES         = 4,
    parameter int         TIMEOUT_CYCLES     = 1024,
    parameter int         MASTER_FRAME_WIDTH = 24,
    parameter int         BRIGHTNESS_WIDTH   = 7,
    parameter logic [7:0] CMD_LED_READ       = 8'h02
) (
    input logic               sysclk,
    input logic               rst,
    spi_cmd_arbiter_if.master bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int M1 = (TX_ENB_CYCLES > GAP_CYCLES) ? TX_ENB_CYCLES : GAP_CYCLES;
    localparam int MC = (TIMEOUT_CYCLES > M1) ? TIMEOUT_CYCLES : M1;
    localparam int CW = $clog2(MC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_START,
        S_WAIT_END,
        S_CAPTURE,
        S_GAP
    } state_e;

    state_e                        state_q, state_d;
    logic [IW-1:0]                 last_q, last_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [MASTER_FRAME_WIDTH-1:0] frame_q, frame_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          to_q, to_d;
    logic [NUM_REQ-1:0]            gnt_q, gnt_d;
    logic [NUM_REQ-1:0]            done_q, done_d;
    logic                          err_q, err_d;
    logic [BRIGHTNESS_WIDTH-1:0]   rdata_q, rdata_d;
    logic                          tx_enb_q;

    logic          win_vld;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    int            sum;
    logic [7:0]    cmd;
    logic          tmo;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] k);
        onehot    = '0;
        onehot[k] = 1'b1;
    endfunction

    assign cmd = frame_q[MASTER_FRAME_WIDTH-1 -: 8];
    assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Search upward from the last winner so a re-queued requester goes last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        sum     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = int'(last_q) + i;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            cand = IW'(sum);
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_vld && bus.cs) begin
                    gnt_d   = onehot(win_idx);
                    frame_d = bus.req_frame[win_idx * MASTER_FRAME_WIDTH +: MASTER_FRAME_WIDTH];
                    idx_d   = win_idx;
                    last_d  = win_idx;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (cnt_q == CW'(TX_ENB_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_START;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_START: begin
                if (!bus.cs) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_END;
                end else if (tmo) begin
                    to_d    = 1'b1;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_END: begin
                if (bus.cs) begin
                    state_d = S_CAPTURE;
                end else if (tmo) begin
                    to_d    = 1'b1;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CAPTURE: begin
                done_d = onehot(idx_q);
                err_d  = to_q;
                if (cmd == CMD_LED_READ) rdata_d = to_q ? '0 : bus.o_frame;
                cnt_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            last_q   <= IW'(NUM_REQ - 1);
            idx_q    <= '0;
            frame_q  <= '0;
            cnt_q    <= '0;
            to_q     <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            tx_enb_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            tx_enb_q <= (state_q == S_LAUNCH);
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.rdata   = rdata_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.tx_enb  = tx_enb_q;
    assign bus.i_frame = frame_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Bench for spi_cmd_arbiter: behavioural SPI master/LED slave plus a
// round-robin and LED-state reference model driven by directed and random steps.
module tb_spi_cmd_arbiter;

    localparam int NR   = 4;
    localparam int TXC  = 2;
    localparam int GAPC = 4;
    localparam int TOC  = 1024;

    localparam logic [7:0] C_NOP  = 8'h00;
    localparam logic [7:0] C_SET  = 8'h01;
    localparam logic [7:0] C_READ = 8'h02;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_cmd_arbiter_if #(.NUM_REQ(NR), .FRAME_W(24), .BRIGHT_W(7)) bus ();

    spi_cmd_arbiter #(
        .NUM_REQ(NR), .TX_ENB_CYCLES(TXC), .GAP_CYCLES(GAPC),
        .TIMEOUT_CYCLES(TOC), .MASTER_FRAME_WIDTH(24),
        .BRIGHTNESS_WIDTH(7), .CMD_LED_READ(C_READ)
    ) dut (
        .sysclk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural master + LED slave
    logic        stub_cs = 1'b0;
    int          low_len = 0;
    logic [23:0] mframe  = '0;
    int          cs_rise = 0;
    logic [6:0]  mled [8];

    initial begin
        logic [7:0] a;
        for (int i = 0; i < 8; i++) mled[i] = '0;
        bus.cs      = 1'b1;
        bus.o_frame = '0;
        forever begin
            @(negedge clk);
            if (bus.tx_enb && !stub_cs) begin
                mframe = bus.i_frame;
                a = mframe[15:8];
                repeat (1 + $urandom_range(0, 2)) @(negedge clk);
                bus.cs = 1'b0;
                if (low_len > 0) repeat (low_len) @(negedge clk);
                else repeat (3 + $urandom_range(0, 4)) @(negedge clk);
                if (mframe[23:16] == C_SET && a < 8) mled[a[2:0]] = mframe[7:1];
                if (mframe[23:16] == C_READ) bus.o_frame = (a < 8) ? mled[a[2:0]] : 7'h00;
                else bus.o_frame = 7'($urandom);
                cs_rise = cyc;
                bus.cs = 1'b1;
            end
        end
    end

    // reference model state
    logic [NR-1:0] pend;
    int            last_m;
    logic [6:0]    rdata_m;
    logic [6:0]    led_m [8];
    logic [23:0]   frames [NR];
    int            last_done;
    bit            b2b;
    bit            rnd_en;
    int            gcyc_g;
    int            w_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    function automatic int rr_pick(input logic [NR-1:0] p, input int last);
        for (int i = 1; i <= NR; i++) begin
            int j;
            j = (last + i) % NR;
            if (p[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [23:0] rnd_frame();
        logic [7:0] c;
        int r;
        r = $urandom_range(0, 3);
        c = (r == 0) ? C_NOP : (r == 1) ? C_SET : (r == 2) ? C_READ : 8'h7E;
        return {c, 8'($urandom_range(0, 9)), 8'($urandom)};
    endfunction

    task automatic set_req(input int k, input logic [23:0] f);
        frames[k] = f;
        bus.req_frame[k*24 +: 24] = f;
        bus.req[k] = 1'b1;
        pend[k] = 1'b1;
    endtask

    task automatic model_reset();
        last_m  = NR - 1;
        rdata_m = '0;
        b2b     = 1'b0;
    endtask

    task automatic chk_reset_outs();
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tx_enb", bus.tx_enb, 0);
        chk("rst_i_frame", bus.i_frame, 0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic serve_one(input logic [NR-1:0] add_mask);
        int w, ntx, txf, dcyc;
        bit ok, bad;
        logic [23:0] f;
        logic [7:0] c, a;
        logic ee;
        w = rr_pick(pend, last_m);
        ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (bus.gnt != 0) begin ok = 1'b1; break; end
        end
        if (!ok || w < 0) begin bound_fail("wait_gnt"); return; end
        gcyc_g = cyc;
        w_g = w;
        chk("gnt_onehot", bus.gnt, 32'(1) << w);
        if (b2b) chk("gnt_after_gap", gcyc_g, last_done + GAPC + 1);
        bus.req[w] = 1'b0;
        pend[w] = 1'b0;
        last_m = w;
        f = frames[w];
        for (int k = 0; k < NR; k++) begin
            if (add_mask[k]) set_req(k, {C_SET, 8'(k), 8'($urandom)});
            else if (rnd_en && !pend[k] && $urandom_range(0, 3) == 0) set_req(k, rnd_frame());
        end
        ntx = 0; txf = -1; bad = 1'b0; ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bus.tx_enb) begin
                ntx++;
                if (txf < 0) txf = cyc;
            end
            if (bus.gnt != 0) bad = 1'b1;
            if (bus.done != 0) begin ok = 1'b1; break; end
            if (bus.i_frame !== f) bad = 1'b1;
        end
        if (!ok) begin bound_fail("wait_done"); return; end
        dcyc = cyc;
        c = f[23:16];
        a = f[15:8];
        ee = stub_cs;
        if (c == C_READ) rdata_m = ee ? 7'h00 : ((a < 8) ? led_m[a[2:0]] : 7'h00);
        if (c == C_SET && a < 8 && !ee) led_m[a[2:0]] = f[7:1];
        chk("done_onehot", bus.done, 32'(1) << w);
        chk("done_err", bus.err, ee);
        chk("done_rdata", bus.rdata, rdata_m);
        chk("tx_enb_len", ntx, TXC);
        chk("tx_enb_start", txf, gcyc_g + 1);
        chk("hold_no_gnt_frame", bad, 0);
        if (ee) begin
            chk("timeout_latency", dcyc, gcyc_g + TXC + TOC + 1);
        end else begin
            chk("done_latency", dcyc, cs_rise + 2);
            chk("master_frame", mframe, f);
        end
        last_done = dcyc;
        b2b = (pend != 0);
    endtask

    initial begin
        int rc, d, lim;
        bit ok, bad;
        rst = 1'b1;
        bus.req = '0;
        bus.req_frame = '0;
        pend = '0;
        rnd_en = 1'b0;
        for (int i = 0; i < 8; i++) led_m[i] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outs();
        rst = 1'b0;

        // single LED set through requester 1
        @(negedge clk);
        set_req(1, {C_SET, 8'h00, {7'h28, 1'b0}});
        rc = cyc;
        serve_one('0);
        chk("gnt_latency", gcyc_g, rc + 1);
        chk("led0_set", mled[0], 7'h28);

        // round-robin order from reset, then re-queue of 0 and 2
        reset_dut();
        for (int k = 0; k < NR; k++) set_req(k, {C_SET, 8'(k), 8'($urandom)});
        for (int k = 0; k < 3; k++) begin
            serve_one('0);
            chk("rr_order", w_g, k);
        end
        serve_one(4'b0101);
        chk("rr_order", w_g, 3);
        serve_one('0);
        chk("rr_requeue", w_g, 0);
        serve_one('0);
        chk("rr_requeue", w_g, 2);

        // read-back, then NOP leaves rdata alone
        set_req(0, {C_SET, 8'h07, {7'h3C, 1'b0}});
        serve_one('0);
        set_req(2, {C_READ, 8'h07, 8'h0C});
        serve_one('0);
        chk("readback", bus.rdata, 7'h3C);
        set_req(1, {C_NOP, 8'h03, 8'h5A});
        serve_one('0);
        chk("nop_keeps_rdata", bus.rdata, 7'h3C);

        // invalid address is passed through and ignored by the slave
        set_req(3, {C_SET, 8'h10, 8'hFF});
        serve_one('0);
        set_req(0, {C_READ, 8'h00, 8'h00});
        set_req(1, {C_READ, 8'h07, 8'h00});
        serve_one('0);
        serve_one('0);
        chk("invalid_addr_led7", bus.rdata, 7'h3C);

        // randomized traffic
        rnd_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (pend == 0) set_req($urandom_range(0, NR - 1), rnd_frame());
            serve_one('0);
        end
        rnd_en = 1'b0;
        while (pend != 0) serve_one('0);

        // timeout in WAIT_START with the master stubbed out
        set_req(0, {C_SET, 8'h06, {7'h55, 1'b0}});
        serve_one('0);
        set_req(1, {C_READ, 8'h06, 8'h00});
        serve_one('0);
        chk("pre_timeout_rdata", bus.rdata, 7'h55);
        stub_cs = 1'b1;
        set_req(3, {C_READ, 8'h06, 8'h00});
        serve_one('0);
        chk("timeout_rdata_zero", bus.rdata, 7'h00);
        repeat (GAPC - 1) @(negedge clk);
        chk("busy_in_gap", bus.busy, 1);
        @(negedge clk);
        chk("busy_after_gap", bus.busy, 0);
        stub_cs = 1'b0;

        // reset while waiting for the end of a frame
        low_len = 20;
        set_req(0, {C_NOP, 8'h00, 8'h00});
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.gnt != 0) begin ok = 1'b1; break; end
        end
        if (!ok) bound_fail("mid_gnt");
        bus.req[0] = 1'b0;
        pend[0] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (!bus.cs) begin ok = 1'b1; break; end
        end
        if (!ok) bound_fail("mid_cs_low");
        low_len = 0;
        repeat (3) @(negedge clk);
        set_req(0, {C_SET, 8'h02, {7'h11, 1'b0}});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_reset_outs();
        bad = 1'b0;
        ok = 1'b0;
        lim = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.gnt != 0 || bus.done != 0) bad = 1'b1;
            #1;
            if (bus.cs) begin ok = 1'b1; break; end
            lim++;
        end
        if (!ok) bound_fail("mid_cs_high");
        chk("no_gnt_done_while_cs_low", bad, 0);
        d = cs_rise;
        serve_one('0);
        chk("post_reset_gnt", gcyc_g, d + 1);
        chk("post_reset_led2", mled[2], 7'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_cmd_arbiter.md
# spi_cmd_arbiter

Master-side command scheduler that shares one `spi_master_mock` (or the equivalent SPI master) among `NUM_REQ` independent requesters. It arbitrates round-robin, launches one 24-bit frame (`{CMD, ADDR, PAYLOAD}`) per grant via `tx_enb`/`i_frame`, and tracks the transaction through `cs`. It returns read-back brightness for `CMD_LED_READ` and signals completion or timeout per requester. All of its logic is in the `sysclk` domain, and the master is also clocked by `sysclk`, so `cs` needs no synchronizer.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TX_ENB_CYCLES`, 2: `sysclk` cycles `tx_enb` is held high per launch, ≥1.
- `GAP_CYCLES`, 4: idle cycles between the end of one transaction and the next grant, ≥1.
- `TIMEOUT_CYCLES`, 1024: maximum cycles waited in each of `WAIT_START` and `WAIT_END`.
- `sysclk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req`  in  `NUM_REQ`  per-requester request level; held until the matching `gnt`.
- `req_frame`  in  `NUM_REQ*MASTER_FRAME_WIDTH`  packed frames, requester k at `[k*24 +: 24]`.
- `gnt`  out  `NUM_REQ`  one-hot, 1-cycle pulse; frame k is latched on this cycle.
- `done`  out  `NUM_REQ`  one-hot, 1-cycle pulse; transaction for k has finished.
- `err`  out  1  qualifies `done`: 1 = timeout.
- `rdata`  out  `BRIGHTNESS_WIDTH`  read-back value; valid with `done`.
- `busy`  out  1  high in every state except `IDLE`.
- `tx_enb`  out  1  to master.
- `i_frame`  out  `MASTER_FRAME_WIDTH`  to master; holds the latched frame from `LAUNCH` through `CAPTURE`.
- `cs`  in  1  from master; active-low transaction window.
- `o_frame`  in  `BRIGHTNESS_WIDTH`  from master; received slave response.

## Operation
- States: `IDLE`, `LAUNCH`, `WAIT_START`, `WAIT_END`, `CAPTURE`, `GAP`.
- `IDLE`:
  - Grants only when `req != 0` and `cs == 1`.
  - Winner is the first set bit searching upward from `last+1`, modulo `NUM_REQ`.
  - On a grant: pulse `gnt[k]`, latch `req_frame[k]` and `k`, set `last <= k`, go to `LAUNCH`.
- `LAUNCH`: `tx_enb = 1` for exactly `TX_ENB_CYCLES` cycles, then `WAIT_START`.
- `WAIT_START`:
  - Wait for `cs == 0`, then go to `WAIT_END`.
  - Timeout after `TIMEOUT_CYCLES` cycles: go to `CAPTURE` with the timeout flag set.
- `WAIT_END`:
  - Wait for `cs == 1`, then go to `CAPTURE`.
  - A separate timeout counter, restarted on entry, applies the same timeout rule.
- `CAPTURE`, one cycle, registered outputs visible on the next cycle:
  - `done[k] <= 1`; `err <=` timeout flag.
  - `rdata <= o_frame` only if `CMD == CMD_LED_READ` and no timeout.
  - On a timeout read, `rdata <= 0`.
  - Otherwise `rdata` is unchanged.
- `GAP`: count `GAP_CYCLES` cycles, then `IDLE`.
- `CMD` is latched frame bits `[23:16]`; the arbiter never decodes `ADDR` or `PAYLOAD`. Invalid addresses pass through unchanged; the slave ignores them.
- A requester whose `req` is still high after `done` is re-queued. It is served again only after the other pending requesters (fairness).
- Reset values:
  - `gnt = 0`, `done = 0`, `err = 0`, `rdata = 0`, `busy = 0`, `tx_enb = 0`, `i_frame = 0`.
  - `last = NUM_REQ-1`, so requester 0 has first priority; state `IDLE`.
- Reset mid-transaction:
  - All outputs return to reset values on the next edge; no `done` is issued for the aborted frame.
  - The `IDLE` rule `cs == 1` prevents launching until the master finishes its in-flight frame.

## Timing
- Edge E: `req[k]` sampled in `IDLE` → `gnt[k]` high during E+1.
- `tx_enb` high during E+2 .. E+1+`TX_ENB_CYCLES`.
- `cs` first seen high at edge F → `done`, `err` and `rdata` valid during F+2 (cycle after `CAPTURE`).
- Earliest next grant: F+2+`GAP_CYCLES`.
- `done` and `gnt` are never asserted in the same cycle. At most one bit of each is set.
- Timeout fires on the `TIMEOUT_CYCLES`-th cycle in the waiting state.
- Simultaneous `req` changes in the grant cycle: the one-hot `gnt` reflects `req` as sampled in `IDLE`.

## Test plan
- Single set: `req[1]` with `{CMD_LED_SET,8'h00,{7'h28,1'b0}}` → one `gnt[1]` pulse; `tx_enb` high 2 cycles; one `done[1]` with `err=0`; `spi_top.led_brightness[0]==7'h28`.
- Round-robin: `req=4'b1111` held, frames targeting addresses 0..3 → grant order 0,1,2,3. Re-asserting `req[0]` and `req[2]` after grant 3 → order 0, 2. No `gnt` within `GAP_CYCLES` of a `done`.
- Read-back: set LED7 to `7'h3C`, then `req[2]` with `{CMD_LED_READ,8'h07,8'h0C}` → `done[2]` with `rdata==7'h3C`. A following `CMD_NOP` leaves `rdata==7'h3C`.
- Timeout: tie `cs=1` (master stubbed) and issue `req[3]` → `done[3]` with `err=1` and `rdata==0` after `TIMEOUT_CYCLES` in `WAIT_START`; `busy` low again after the gap.
- Reset mid-operation: assert `rst` for 1 cycle while in `WAIT_END` → all outputs 0 next cycle; no `done`. A pending `req[0]` is granted only after `cs` returns high.
- Invalid address: `{CMD_LED_SET,8'h10,8'hFF}` → normal `done`, `err=0`; LED0 and LED7 brightness unchanged.
